// File: rtl/dsp_result_sink.sv
// -----------------------------------------------------------------------------
// dsp_result_sink
//
// Collects results from a pipelined DSP slice into a small show-ahead buffer.
// An operand is only issued into the slice when the buffer is guaranteed to
// have room for its result: in_ready is a credit that counts both the entries
// already buffered and the tokens still travelling through the slice pipeline.
// A shift register of valid bits mirrors the slice pipeline, so the result
// for each issued operand is captured exactly PIPE_DEPTH cycles after issue.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// when valid and ready are both 1 in the cycle that edge closes. in_ready is
// derived from registered state only. out_valid/out_data/out_carry are
// registered state and never depend combinationally on out_ready.
//
// Parameters
//   WIDTH      : width of the slice P result
//   PIPE_DEPTH : slice register stages between operand issue and P valid (0..4)
//   FIFO_DEPTH : result buffer entries (power of two, 2..16)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream requests an operand issue this cycle
//   in_ready   : a result credit is available (usable as slice CE qualifier)
//   p_in       : slice P output
//   carry_in   : slice CARRYOUT
//   out_valid  : buffer head is valid
//   out_ready  : downstream accepts the head
//   out_data   : head result
//   out_carry  : head carry
//   level      : buffer occupancy
//   drop_err   : sticky, in_valid was seen while in_ready was low
// -----------------------------------------------------------------------------
module dsp_result_sink #(
  parameter int WIDTH      = 48,
  parameter int PIPE_DEPTH = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              p_in,
  input  logic                          carry_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_carry,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          drop_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  // Keep the valid shift register at least one bit wide so the PIPE_DEPTH=0
  // build still has a well-formed (constant zero) vector to count.
  localparam int SRW = (PIPE_DEPTH == 0) ? 1 : PIPE_DEPTH;

  logic             issue;
  logic             arrive;
  logic             push;
  logic             pop;
  logic [SRW-1:0]   vsr;
  logic [7:0]       inflight;
  logic [7:0]       credit_sum;

  logic [WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;

  assign issue = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Token tracking: one valid bit per slice register stage.
  // ---------------------------------------------------------------------------
  if (PIPE_DEPTH == 0) begin : g_comb
    // No slice registers: the result is present in the issue cycle itself.
    assign vsr    = '0;
    assign arrive = issue;
  end else begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        vsr <= '0;
      end else begin
        vsr[0] <= issue;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          vsr[i] <= vsr[i-1];
        end
      end
    end
    assign arrive = vsr[PIPE_DEPTH-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRW; i++) begin
      inflight = inflight + 8'(vsr[i]);
    end
  end

  // Credit: tokens in the pipe are already committed to buffer slots, so they
  // count against the depth exactly like stored entries. A pop in this cycle
  // frees a slot only once level has actually dropped (next cycle).
  assign credit_sum = 8'(level) + inflight;
  assign in_ready   = (credit_sum < 8'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // Arrival into a full buffer cannot happen while the credit rule holds; if
  // it ever did, the data is dropped rather than overwriting the head.
  assign push      = arrive & (level != LW'(FIFO_DEPTH));

  assign out_data  = mem[rptr][WIDTH-1:0];
  assign out_carry = mem[rptr][WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= {carry_in, p_in};
    end
  end

  // Pointers are AW bits wide and FIFO_DEPTH is a power of two, so plain
  // increment wraps modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_result_sink.sv
// -----------------------------------------------------------------------------
// tb_dsp_result_sink
//
// Directed bench for dsp_result_sink. Two instances share clk/rst:
//   dut  : PIPE_DEPTH=3, FIFO_DEPTH=4, WIDTH=48
//   dut0 : PIPE_DEPTH=0, FIFO_DEPTH=4, WIDTH=48
// Inputs change and outputs are sampled just after the falling edge, so each
// "cycle" below is the interval closed by the next rising edge.
// -----------------------------------------------------------------------------
module tb_dsp_result_sink;

  localparam int WIDTH = 48;
  localparam int LW    = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // PIPE_DEPTH=3 instance signals
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] p_in      = '0;
  logic             carry_in  = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic [LW-1:0]    level;
  logic             drop_err;

  // PIPE_DEPTH=0 instance signals
  logic             in_valid0  = 1'b0;
  logic             in_ready0;
  logic [WIDTH-1:0] p_in0      = '0;
  logic             carry_in0  = 1'b0;
  logic             out_valid0;
  logic             out_ready0 = 1'b0;
  logic [WIDTH-1:0] out_data0;
  logic             out_carry0;
  logic [LW-1:0]    level0;
  logic             drop_err0;

  dsp_result_sink #(.WIDTH(WIDTH), .PIPE_DEPTH(3), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .level     (level),
    .drop_err  (drop_err)
  );

  dsp_result_sink #(.WIDTH(WIDTH), .PIPE_DEPTH(0), .FIFO_DEPTH(4)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .p_in      (p_in0),
    .carry_in  (carry_in0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_data  (out_data0),
    .out_carry (out_carry0),
    .level     (level0),
    .drop_err  (drop_err0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; p_in = '0; carry_in = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; p_in0 = '0; carry_in0 = 1'b0;
    repeat (cycles) next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    next_cycle();
    do_reset(2);

    // --- reset state ------------------------------------------------------
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_level",     64'(level),     64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_carry", 64'(out_carry), 64'd0);
    check_eq("rst_drop_err",  64'(drop_err),  64'd0);
    check_eq("rst0_out_data", 64'(out_data0), 64'd0);

    // --- single-issue latency: issue in cycle t, result in t+3, visible t+4
    out_ready = 1'b1;
    in_valid  = 1'b1;                       // cycle t
    next_cycle(); in_valid = 1'b0;          // t+1
    check_eq("lat_ready_t1", 64'(in_ready), 64'd1);
    next_cycle();                           // t+2
    next_cycle();                           // t+3: arrival cycle
    p_in = 48'h0000_0000_1234;
    check_eq("lat_no_bypass", 64'(out_valid), 64'd0);
    next_cycle(); p_in = 48'hDEAD_BEEF_0000; // t+4
    check_eq("lat_out_valid", 64'(out_valid), 64'd1);
    check_eq("lat_out_data",  64'(out_data),  64'h1234);
    check_eq("lat_level",     64'(level),     64'd1);
    next_cycle();                           // t+5: popped at end of t+4
    check_eq("lat_level_after", 64'(level),     64'd0);
    check_eq("lat_valid_after", 64'(out_valid), 64'd0);

    // --- backpressure: 4 issues, then refused; results 1..4 --------------
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      // issue k arrives at cycle k+3 carrying value k+1
      p_in = (i >= 3) ? 48'(i - 2) : 48'hBAD;
      check_eq($sformatf("bp_ready_%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      check_eq($sformatf("bp_level_%0d", i), 64'(level),
               (i < 3) ? 64'd0 : ((i > 7) ? 64'd4 : 64'(i - 3)));
      check_eq($sformatf("bp_drop_%0d", i), 64'(drop_err), (i >= 5) ? 64'd1 : 64'd0);
      next_cycle();
    end
    in_valid = 1'b0;
    p_in = 48'hBAD;
    check_eq("bp_level_full", 64'(level), 64'd4);

    // --- drain order 1,2,3,4 ---------------------------------------------
    for (int v = 1; v <= 4; v++) exp_q.push_back(48'(v));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("drain_data_%0d", i), 64'(out_data), 64'(e));
      check_eq($sformatf("drain_level_%0d", i), 64'(level), 64'(4 - i));
      // credit returns one cycle after the first pop
      check_eq($sformatf("drain_ready_%0d", i), 64'(in_ready), (i == 0) ? 64'd0 : 64'd1);
      next_cycle();
    end
    check_eq("drain_level_end", 64'(level),     64'd0);
    check_eq("drain_valid_end", 64'(out_valid), 64'd0);
    check_eq("drain_drop_sticky", 64'(drop_err), 64'd1);
    out_ready = 1'b0;

    do_reset(1);
    check_eq("drop_cleared", 64'(drop_err), 64'd0);

    // --- simultaneous push/pop at level 2 --------------------------------
    // issues at s,s+1,s+2 with results 0x10,0x11,0x12 arriving s+3..s+5
    for (int v = 16; v <= 18; v++) exp_q.push_back(48'(v));
    for (int i = 0; i < 8; i++) begin
      in_valid  = (i < 3);
      p_in      = (i >= 3 && i <= 5) ? 48'(16 + i - 3) : 48'hBAD;
      carry_in  = (i == 4);                 // middle result carries
      out_ready = (i >= 5);
      if (i == 5) begin
        check_eq("pp_level_before", 64'(level), 64'd2);
      end
      if (i >= 5) begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check_eq($sformatf("pp_data_%0d", i), 64'(out_data), 64'(e));
        check_eq($sformatf("pp_carry_%0d", i), 64'(out_carry), (i == 6) ? 64'd1 : 64'd0);
        check_eq($sformatf("pp_level_%0d", i), 64'(level), (i == 7) ? 64'd1 : 64'd2);
      end
      next_cycle();
    end
    check_eq("pp_level_end", 64'(level), 64'd0);
    out_ready = 1'b0; carry_in = 1'b0;

    // --- mid-flight reset --------------------------------------------------
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; p_in = 48'h5A5A; next_cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;                              // first token arrives this cycle
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("mfr_valid_%0d", i), 64'(out_valid), 64'd0);
      check_eq($sformatf("mfr_level_%0d", i), 64'(level),     64'd0);
      check_eq($sformatf("mfr_ready_%0d", i), 64'(in_ready),  64'd1);
      next_cycle();
    end
    p_in = '0;

    // --- PIPE_DEPTH=0: arrival in the issue cycle --------------------------
    in_valid0 = 1'b1; p_in0 = 48'hFFFF_FFFF_FFFF; carry_in0 = 1'b1;
    check_eq("pd0_no_bypass", 64'(out_valid0), 64'd0);
    next_cycle();
    in_valid0 = 1'b0; p_in0 = '0; carry_in0 = 1'b0;
    check_eq("pd0_out_valid", 64'(out_valid0), 64'd1);
    check_eq("pd0_out_data",  64'(out_data0),  64'hFFFF_FFFF_FFFF);
    check_eq("pd0_out_carry", 64'(out_carry0), 64'd1);
    check_eq("pd0_level",     64'(level0),     64'd1);
    out_ready0 = 1'b1;
    next_cycle();
    out_ready0 = 1'b0;
    check_eq("pd0_level_after", 64'(level0), 64'd0);

    // --- final report ------------------------------------------------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_result_sink.md
DSP_RESULT_SINK -- requirements
Module: dsp_result_sink

Interface
REQ-001 SHALL have parameter WIDTH, default 48, meaning the width of the slice P result.
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, range 0..4, meaning the slice register stages between operand issue and P valid.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, a power of two in 2..16, meaning the result buffer entries.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream requests an operand issue into the slice this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: a result credit is available, and the slice CE may be driven from issue.
REQ-008 SHALL have port p_in, input, WIDTH bits: the slice P output.
REQ-009 SHALL have port carry_in, input, 1 bit: the slice CARRYOUT.
REQ-010 SHALL have port out_valid, output, 1 bit: the buffer head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream accepts the head.
REQ-012 SHALL have port out_data, output, WIDTH bits: the head result.
REQ-013 SHALL have port out_carry, output, 1 bit: the head carry.
REQ-014 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: the buffer occupancy.
REQ-015 SHALL have port drop_err, output, 1 bit: sticky flag meaning in_valid was seen while in_ready was low.

Function
REQ-016 SHALL define issue = in_valid & in_ready; in_valid while in_ready=0 SHALL NOT create a token.
REQ-017 SHALL track tokens in a PIPE_DEPTH-stage valid shift register; a token issued in cycle t SHALL arrive in cycle t+PIPE_DEPTH.
REQ-018 With PIPE_DEPTH=0, arrival SHALL equal issue in the same cycle, with p_in sampled combinationally from that cycle.
REQ-019 On arrival, {carry_in, p_in} SHALL be written to the buffer tail at the clock edge ending the arrival cycle.
REQ-020 inflight SHALL equal the number of set bits in the valid shift register, with range 0..PIPE_DEPTH.
REQ-021 in_ready SHALL be 1 iff level + inflight < FIFO_DEPTH, computed from registered state only. A same-cycle pop SHALL NOT grant credit until the next cycle.
REQ-022 The buffer SHALL be show-ahead: out_data and out_carry SHALL present the head whenever out_valid=1.
REQ-023 out_valid SHALL be 1 iff level != 0.
REQ-024 pop = out_valid & out_ready; the head pointer SHALL advance on pop.
REQ-025 On simultaneous arrival and pop, level SHALL be unchanged; if level=0, arrival SHALL NOT bypass to the output in the same cycle, and out_valid SHALL rise one cycle later.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Because of the credit rule, an arrival into a full buffer SHALL be unreachable; the design SHALL still drop such data and leave level at FIFO_DEPTH.
REQ-028 A pop when level=0 SHALL be ignored.
REQ-029 drop_err SHALL set on any cycle with in_valid=1 and in_ready=0, and SHALL remain set until rst.
REQ-030 out_data and out_carry contents while out_valid=0 SHALL be don't-care to consumers, but SHALL be driven from storage (no X after reset).

Reset
REQ-031 On rst=1 at a clock edge, the design SHALL clear the valid shift register, the pointers, level and drop_err. After that edge, in_ready=1, out_valid=0, level=0, out_data=0, out_carry=0, and drop_err=0.
REQ-032 Reset SHALL override same-cycle issue, arrival and pop, and SHALL discard in-flight tokens mid-operation.
REQ-033 Storage contents SHALL be zeroed on reset.

Verification
REQ-034 Single-issue latency test (PIPE_DEPTH=3): issue at cycle 5 with p_in=0x0000_0000_1234 at cycle 8 and out_ready=1 -> out_valid=1 at cycle 9, out_data=0x1234, level=1 for 1 cycle.
REQ-035 Backpressure test (FIFO_DEPTH=4, out_ready=0): in_valid held at 1 -> 4 issues accepted, in_ready=0 from the 5th cycle, level reaches 4, and drop_err=1 after the first refused cycle.
REQ-036 Drain order test: after filling with results 1,2,3,4, set out_ready=1 -> out_data sequence is 1,2,3,4 on consecutive cycles, level returns to 0, and in_ready=1 one cycle after the first pop.
REQ-037 Simultaneous push/pop test: level=2 with arrival and pop in the same cycle -> level stays 2 and order is preserved.
REQ-038 Mid-flight reset test: 3 tokens in flight, rst pulsed for 1 cycle -> no result ever appears, level=0, and in_ready=1.
REQ-039 PIPE_DEPTH=0 test: issue with p_in=0xFFFF_FFFF_FFFF and carry_in=1 -> next cycle out_valid=1, out_data=0xFFFF_FFFF_FFFF, and out_carry=1.
